// File: rtl/mips_id_stage.sv
// mips_id_stage
//   Decode / operand-fetch stage feeding a 32-bit MIPS ALU.
//   The stage decodes the R/I-type arithmetic-logic subset into a 3-bit ALU
//   op and reads rs/rt from an internal 32x32 register file.
//   A per-register busy scoreboard holds issue back until any outstanding
//   writeback to a source or destination register has landed.
//   The result is held in a single ID/EX register.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  instruction handshake; in_ready ignores in_valid
//   instr           instruction word
//   wb_en/addr/data writeback port from downstream
//   ex_stall        hold the EX register
//   flush           kill the EX register and drop the current input
//   out_valid       EX register holds a live instruction
//   alu_a/b/opr/cin ALU operands and op (cin tied 0)
//   dst_reg/dst_we  destination index and write enable
//   illegal         instruction outside the decoded subset
module mips_id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_opr,
  output logic        alu_cin,
  output logic [4:0]  dst_reg,
  output logic        dst_we,
  output logic        illegal
);

  localparam logic [2:0] OPR_NONE = 3'b000;
  localparam logic [2:0] OPR_ADD  = 3'b001;
  localparam logic [2:0] OPR_SUB  = 3'b010;
  localparam logic [2:0] OPR_AND  = 3'b011;
  localparam logic [2:0] OPR_OR   = 3'b100;
  localparam logic [2:0] OPR_SLT  = 3'b101;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        unused_shamt;

  assign op           = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = instr[5:0];
  assign imm          = instr[15:0];
  assign unused_shamt = ^instr[10:6];

  logic        is_rtype;
  logic        dec_legal;
  logic [2:0]  dec_opr;
  logic [4:0]  dec_dst;
  logic        dec_use_imm;
  logic        dec_sext;
  logic        dec_we;
  logic [31:0] imm_ext;

  assign is_rtype = (op == 6'h00);

  always_comb begin
    dec_legal   = 1'b0;
    dec_opr     = OPR_NONE;
    dec_dst     = rt;
    dec_use_imm = 1'b0;
    dec_sext    = 1'b0;
    if (is_rtype) begin
      dec_dst = rd;
      unique case (funct)
        6'h20, 6'h21: begin dec_legal = 1'b1; dec_opr = OPR_ADD; end
        6'h22, 6'h23: begin dec_legal = 1'b1; dec_opr = OPR_SUB; end
        6'h24:        begin dec_legal = 1'b1; dec_opr = OPR_AND; end
        6'h25:        begin dec_legal = 1'b1; dec_opr = OPR_OR;  end
        6'h2A:        begin dec_legal = 1'b1; dec_opr = OPR_SLT; end
        default:      ;
      endcase
    end else begin
      dec_use_imm = 1'b1;
      unique case (op)
        6'h08, 6'h09: begin dec_legal = 1'b1; dec_opr = OPR_ADD; dec_sext = 1'b1; end
        6'h0A:        begin dec_legal = 1'b1; dec_opr = OPR_SLT; dec_sext = 1'b1; end
        6'h0C:        begin dec_legal = 1'b1; dec_opr = OPR_AND; end
        6'h0D:        begin dec_legal = 1'b1; dec_opr = OPR_OR;  end
        default:      ;
      endcase
    end
  end

  assign dec_we  = dec_legal && (dec_dst != 5'd0);
  assign imm_ext = dec_sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};

  // Register file with write-first bypass on the read ports.
  logic [31:0] rf [32];
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  always_comb begin
    if (rs == 5'd0)                     rs_val = 32'h0;
    else if (wb_en && (wb_addr == rs))  rs_val = wb_data;
    else                                rs_val = rf[rs];
    if (rt == 5'd0)                     rt_val = 32'h0;
    else if (wb_en && (wb_addr == rt))  rt_val = wb_data;
    else                                rt_val = rf[rt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Scoreboard. A register being written back this cycle is treated as free
  // so the dependent instruction issues in the same cycle as its producer's
  // writeback.
  logic [31:0] busy;
  logic [31:0] busy_eff;
  logic [31:0] wb_mask;
  logic [31:0] flush_mask;
  logic [31:0] set_mask;
  logic [31:0] busy_next;
  logic        hazard;
  logic        issue;

  assign wb_mask  = wb_en ? (32'h1 << wb_addr) : 32'h0;
  assign busy_eff = busy & ~wb_mask;
  assign hazard   = busy_eff[rs] | (is_rtype & busy_eff[rt]) | (dec_we & busy_eff[dec_dst]);
  assign in_ready = !ex_stall && !flush && !hazard;
  assign issue    = in_valid && in_ready;

  // A flushed producer will never write back, so its busy bit is released.
  assign flush_mask = (flush && out_valid && dst_we) ? (32'h1 << dst_reg) : 32'h0;
  assign set_mask   = (issue && dec_we) ? (32'h1 << dec_dst) : 32'h0;
  assign busy_next  = ((busy & ~wb_mask & ~flush_mask) | set_mask) & 32'hFFFF_FFFE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 32'h0;
    else     busy <= busy_next;
  end

  // ID/EX register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_a     <= 32'h0;
      alu_b     <= 32'h0;
      alu_opr   <= OPR_NONE;
      dst_reg   <= 5'd0;
      dst_we    <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!ex_stall) begin
      out_valid <= issue;
      if (issue) begin
        alu_a   <= rs_val;
        alu_b   <= dec_use_imm ? imm_ext : rt_val;
        alu_opr <= dec_opr;
        dst_reg <= dec_dst;
        dst_we  <= dec_we;
        illegal <= !dec_legal;
      end
    end
  end

  assign alu_cin = 1'b0;

endmodule

// File: tb/tb_mips_id_stage.sv
// Testbench for mips_id_stage: directed instruction sequence, a reference
// model of the stage's architectural behaviour checked every cycle, and
// literal expectations at the key points of the sequence.
module tb_mips_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        ex_stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_opr;
  logic        alu_cin;
  logic [4:0]  dst_reg;
  logic        dst_we;
  logic        illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush), .out_valid(out_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opr(alu_opr), .alu_cin(alu_cin),
    .dst_reg(dst_reg), .dst_we(dst_we), .illegal(illegal)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        legal;
    logic [2:0]  opr;
    logic [4:0]  dst;
    logic        uses_rt;   // rt participates as a source (R-type)
    logic [31:0] bimm;      // extended immediate, valid when !uses_rt
  } dec_t;

  logic [31:0] m_rf [32];
  bit          m_busy [32];
  logic        m_ov, m_we, m_ill;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_opr;
  logic [4:0]  m_dst;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    logic [15:0] im;
    im = w[15:0];
    d.legal = 1'b1; d.opr = 3'd0; d.uses_rt = 1'b0; d.dst = w[20:16]; d.bimm = 32'h0;
    if (w[31:26] == 6'd0) begin
      d.uses_rt = 1'b1;
      d.dst = w[15:11];
      case (w[5:0])
        6'h20, 6'h21: d.opr = 3'd1;
        6'h22, 6'h23: d.opr = 3'd2;
        6'h24:        d.opr = 3'd3;
        6'h25:        d.opr = 3'd4;
        6'h2A:        d.opr = 3'd5;
        default:      d.legal = 1'b0;
      endcase
    end else begin
      case (w[31:26])
        6'h08, 6'h09: begin d.opr = 3'd1; d.bimm = 32'(signed'(im)); end
        6'h0A:        begin d.opr = 3'd5; d.bimm = 32'(signed'(im)); end
        6'h0C:        begin d.opr = 3'd3; d.bimm = {16'h0, im}; end
        6'h0D:        begin d.opr = 3'd4; d.bimm = {16'h0, im}; end
        default:      d.legal = 1'b0;
      endcase
    end
    if (!d.legal) d.opr = 3'd0;
    return d;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_en && wb_addr == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic bit m_is_busy(input logic [4:0] r);
    return (r != 0) && m_busy[r] && !(wb_en && wb_addr == r);
  endfunction

  function automatic logic m_ready();
    dec_t d;
    bit hz;
    d  = decode(instr);
    hz = m_is_busy(instr[25:21]) || (d.uses_rt && m_is_busy(instr[20:16])) ||
         (d.legal && d.dst != 0 && m_is_busy(d.dst));
    return !ex_stall && !flush && !hz;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_rf[i] = 32'h0; m_busy[i] = 0; end
      m_ov = 0; m_we = 0; m_ill = 0; m_a = 0; m_b = 0; m_opr = 0; m_dst = 0;
    end else begin
      dec_t d;
      logic iss, dwe;
      logic [31:0] a, b;
      d   = decode(instr);
      dwe = d.legal && d.dst != 0;
      iss = in_valid && m_ready();
      a   = m_read(instr[25:21]);
      b   = d.uses_rt ? m_read(instr[20:16]) : d.bimm;
      if (wb_en) m_busy[wb_addr] = 0;
      if (flush && m_ov && m_we) m_busy[m_dst] = 0;
      if (iss && dwe) m_busy[d.dst] = 1;
      if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
      if (flush) m_ov = 0;
      else if (!ex_stall) begin
        m_ov = iss;
        if (iss) begin
          m_a = a; m_b = b; m_opr = d.opr; m_dst = d.dst; m_we = dwe; m_ill = !d.legal;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("m.in_ready",  32'(in_ready),  32'(m_ready()));
      chk("m.out_valid", 32'(out_valid), 32'(m_ov));
      chk("m.alu_a",     alu_a,          m_a);
      chk("m.alu_b",     alu_b,          m_b);
      chk("m.alu_opr",   32'(alu_opr),   32'(m_opr));
      chk("m.alu_cin",   32'(alu_cin),   32'h0);
      chk("m.dst_reg",   32'(dst_reg),   32'(m_dst));
      chk("m.dst_we",    32'(dst_we),    32'(m_we));
      chk("m.illegal",   32'(illegal),   32'(m_ill));
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic v, input logic [31:0] i, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic st, input logic fl);
    in_valid = v; instr = i; wb_en = we; wb_addr = wa; wb_data = wd;
    ex_stall = st; flush = fl;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle(); put(0, 32'h0, 0, 0, 0, 0, 0); endtask

  task automatic issue(input logic [31:0] i); put(1, i, 0, 0, 0, 0, 0); cyc(); endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d); put(0, 32'h0, 1, a, d, 0, 0); cyc(); endtask

  initial begin
    #12;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.alu_b",     alu_b,          0);
    chk("rst.dst_we",    32'(dst_we),    0);
    @(negedge clk); rst = 1'b0;
    cyc();

    // ADDI r1,r0,5
    issue(32'h20010005);
    chk("addi.out_valid", 32'(out_valid), 1);
    chk("addi.alu_a",     alu_a, 0);
    chk("addi.alu_b",     alu_b, 5);
    chk("addi.alu_opr",   32'(alu_opr), 1);
    chk("addi.dst_reg",   32'(dst_reg), 1);
    chk("addi.dst_we",    32'(dst_we),  1);

    // ADD r2,r1,r1 stalls on r1, issues with its writeback
    put(1, 32'h00211020, 0, 0, 0, 0, 0); #1;
    chk("raw.stall_ready", 32'(in_ready), 0);
    cyc();
    put(1, 32'h00211020, 1, 5'd1, 32'd5, 0, 0); #1;
    chk("raw.wb_ready", 32'(in_ready), 1);
    cyc();
    chk("raw.alu_a",   alu_a, 5);
    chk("raw.alu_b",   alu_b, 5);
    chk("raw.alu_opr", 32'(alu_opr), 1);
    chk("raw.dst_reg", 32'(dst_reg), 2);
    wb(5'd2, 32'd10);

    // ORI / SLTI immediate extension; SLTI's dst is freed by same-cycle wb
    issue(32'h34038000);
    chk("ori.alu_b",   alu_b, 32'h0000_8000);
    chk("ori.alu_opr", 32'(alu_opr), 4);
    put(1, 32'h28038000, 1, 5'd3, 32'd1, 0, 0); cyc();
    chk("slti.alu_b",   alu_b, 32'hFFFF_8000);
    chk("slti.alu_opr", 32'(alu_opr), 5);
    wb(5'd3, 32'd2);

    // illegal words and r0 destination
    issue(32'hFC1F0000);
    chk("ill.illegal", 32'(illegal), 1);
    chk("ill.alu_opr", 32'(alu_opr), 0);
    chk("ill.dst_we",  32'(dst_we),  0);
    put(1, 32'h001F0020, 0, 0, 0, 0, 0); #1;   // ADD r0,r0,r31: r31 must be free
    chk("ill.nobusy_ready", 32'(in_ready), 1);
    cyc();
    issue(32'h00000000);
    chk("ill_r.illegal", 32'(illegal), 1);
    issue(32'h20000001);
    chk("r0.dst_we",  32'(dst_we),  0);
    chk("r0.illegal", 32'(illegal), 0);

    // ex_stall hold
    issue(32'h20050007);
    for (int k = 0; k < 3; k++) begin
      put(1, 32'h20060009, 0, 0, 0, 1, 0); #1;
      chk("stall.ready", 32'(in_ready), 0);
      cyc();
      chk("stall.alu_b",   alu_b, 7);
      chk("stall.dst_reg", 32'(dst_reg), 5);
      chk("stall.valid",   32'(out_valid), 1);
    end
    issue(32'h20060009);
    chk("release.alu_b",   alu_b, 9);
    chk("release.dst_reg", 32'(dst_reg), 6);

    // flush frees r4 while a writeback to r6 lands in the same cycle
    issue(32'h20040003);
    put(0, 32'h0, 1, 5'd6, 32'd9, 0, 1); cyc();
    chk("flush.out_valid", 32'(out_valid), 0);
    put(1, 32'h00843820, 0, 0, 0, 0, 0); #1;
    chk("flush.r4_ready", 32'(in_ready), 1);
    cyc();
    chk("flush.add_valid", 32'(out_valid), 1);
    chk("flush.add_dst",   32'(dst_reg), 7);

    // set wins over same-cycle writeback
    put(1, 32'h200D0001, 1, 5'd13, 32'd77, 0, 0); cyc();
    put(1, 32'h01A07020, 0, 0, 0, 0, 0); #1;     // ADD r14,r13,r0
    chk("setwins.ready", 32'(in_ready), 0);
    cyc();

    // R-type data mix
    wb(5'd10, 32'h1234_5678);
    wb(5'd11, 32'hF0F0_F0F0);
    issue(32'h014B6024);                           // AND r12,r10,r11
    chk("and.alu_a", alu_a, 32'h1234_5678);
    chk("and.alu_b", alu_b, 32'hF0F0_F0F0);
    chk("and.opr",   32'(alu_opr), 3);
    issue(32'h014B7822);                           // SUB r15,r10,r11
    issue(32'h014B802A);                           // SLT r16,r10,r11
    issue(32'h3151FFFF);                           // ANDI r17,r10,0xFFFF
    chk("andi.alu_b", alu_b, 32'h0000_FFFF);
    issue(32'h2152FFFF);                           // ADDI r18,r10,-1
    chk("addi_neg.alu_b", alu_b, 32'hFFFF_FFFF);

    // reset mid-stall: r5 still busy, ex_stall high
    put(1, 32'h00A04020, 0, 0, 0, 1, 0); #1;
    chk("prerst.ready", 32'(in_ready), 0);
    #2 rst = 1'b1; #1;
    chk("midrst.out_valid", 32'(out_valid), 0);
    chk("midrst.alu_a",     alu_a, 0);
    chk("midrst.dst_we",    32'(dst_we), 0);
    @(posedge clk); #1;
    put(1, 32'h00A04020, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("postrst.ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    issue(32'h00214820);                           // ADD r9,r1,r1: rf cleared
    chk("postrst.alu_a", alu_a, 0);
    chk("postrst.dst",   32'(dst_reg), 9);
    idle(); cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_id_stage.md
# mips_id_stage

Decode/operand-fetch stage directly upstream of the 32-bit MIPS ALU. Accepts one instruction word per cycle, decodes the R/I-type arithmetic-logic subset into the ALU's 3-bit operation code, and reads operands from an internal 32x32 register file. A single-entry ID/EX pipeline register drives the ALU's A, B, Cin and opr inputs. A per-register scoreboard stalls issue until an outstanding writeback to a source or destination register has landed.

## Interface
- No parameters. Data width is fixed at 32 and the register count at 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instr holds a valid instruction.
- in_ready  out  1  stage accepts instr this cycle.
- instr  in  32  MIPS instruction word.
- wb_en  in  1  writeback strobe from the downstream stage.
- wb_addr  in  5  writeback register index.
- wb_data  in  32  writeback value.
- ex_stall  in  1  downstream hold; the EX register must not change.
- flush  in  1  kill the EX register contents and drop the current input.
- out_valid  out  1  EX register holds a live instruction.
- alu_a  out  32  ALU operand A (rs value).
- alu_b  out  32  ALU operand B (rt value or extended immediate).
- alu_opr  out  3  ALU op: ADD=001, SUB=010, AND=011, OR=100, SLT=101.
- alu_cin  out  1  always 0.
- dst_reg  out  5  destination register index.
- dst_we  out  1  instruction writes dst_reg.
- illegal  out  1  instruction is outside the decoded subset.

## Operation
- Field positions: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0].
- R-type (op=0) funct decode:
  - 0x20 and 0x21 → ADD.
  - 0x22 and 0x23 → SUB.
  - 0x24 → AND.
  - 0x25 → OR.
  - 0x2A → SLT.
  - For all of these: B=rt value, dst=rd.
- I-type decode, all with dst=rt:
  - 0x08 and 0x09 → ADD, sign-extended imm.
  - 0x0A → SLT, sign-extended imm.
  - 0x0C → AND, zero-extended imm.
  - 0x0D → OR, zero-extended imm.
- Any other op or funct: illegal=1, alu_opr=000, dst_we=0. The instruction still flows through and no scoreboard bit is set.
- dst_we=1 only if the instruction is legal and dst≠0.
- Register file:
  - r0 always reads 0 and writes to r0 are discarded.
  - Write occurs on the clock edge when wb_en=1.
  - Reads are combinational and write-first: if wb_en=1 and wb_addr equals a nonzero source, the read returns wb_data in the same cycle.
- Scoreboard (busy[31:0], busy[0] hardwired 0):
  - hazard = (rs busy, or rt busy when the op is R-type, or dst busy when dst_we=1).
  - A busy bit whose register is being written back this cycle (wb_en=1 and wb_addr matches) counts as not busy.
  - Busy bits are set on issue when dst_we=1.
  - Busy bits are cleared on wb_en=1 for wb_addr.
  - If set and clear hit the same register in the same cycle, set wins.
  - On flush with out_valid=1 and dst_we=1, busy[dst_reg] is cleared. This clear takes priority over a writeback clear to a different register; both apply.
- in_ready = !ex_stall & !flush & !hazard. in_ready is evaluated independently of in_valid.
- Issue occurs when in_valid and in_ready are both 1.
- EX register update priority:
  1. flush: out_valid←0; the other EX fields hold.
  2. ex_stall: all EX fields hold.
  3. Otherwise: out_valid←issue. All fields load on issue; when there is no issue, only out_valid changes.

## Timing
- Reset (async, immediate): out_valid=0, alu_a=0, alu_b=0, alu_opr=000, alu_cin=0, dst_reg=0, dst_we=0, illegal=0. All registers and all busy bits clear.
- Latency: an instruction issued at edge N is presented on the outputs after edge N, for one cycle, or longer while ex_stall=1.
- Throughput: 1 instruction per cycle with no hazards.
- Dependency penalty: a dependent instruction stalls until the cycle in which its producer's wb_en is asserted, and issues in that same cycle.
- Reset asserted mid-stall discards the EX register contents and all scoreboard state.

## Test plan
- Reset, then issue ADDI r1,r0,5 (0x20010005) → next cycle: out_valid=1, alu_a=0, alu_b=5, alu_opr=001, dst_reg=1, dst_we=1. busy[1]=1.
- With r1 busy, present ADD r2,r1,r1 (0x00211020) → in_ready=0. Assert wb_en, wb_addr=1, wb_data=5 → in_ready=1 that cycle. Next cycle: alu_a=5, alu_b=5, alu_opr=001, dst_reg=2.
- ORI r3,r0,0x8000 → alu_b=0x00008000. SLTI r3,r0,0x8000 → alu_b=0xFFFF8000, alu_opr=101.
- Instruction 0xFC000000 → illegal=1, alu_opr=000, dst_we=0, no busy bit set. ADDI r0,r0,1 → dst_we=0.
- Hold ex_stall=1 for 3 cycles with in_valid=1 → in_ready=0 and the outputs are unchanged. Release → the pending instruction issues the next edge.
- Issue a write to r4, then assert flush → out_valid=0 next cycle, busy[4]=0. A following ADD using r4 issues without stalling.
